// File: rtl/rom_reader.sv
// Burst read engine: walks a wrapping rom address range and streams the words out with a last flag.
// Latency: start in cycle 0 -> rom_en in cycle 1 -> m_valid in cycle 3; one word per cycle while m_ready is high.
// Backpressure: reads are throttled so that queued words plus outstanding reads never exceed 4; m_data/m_last hold while stalled.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset (shared with the rom)
//   start, base, count  burst command; accepted only while idle (busy == 0)
//   busy, done          busy spans accepted start through the done cycle; done is a 1-cycle pulse
//   rom_en, rom_adr     read request to the rom; rom_dat returns the word one cycle later
//   m_valid, m_ready    output stream handshake; m_data is the word, m_last marks the final word
module rom_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic             rom_en,
    output logic [AW-1:0]    rom_adr,
    input  logic [WIDTH-1:0] rom_dat,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW:0]       issue_left_q, issue_left_d;
    logic [AW:0]       beats_left_q, beats_left_d;

    // v1_q marks that the rom's data register loads a word for us this cycle,
    // i.e. rom_dat is valid now and gets pushed into the FIFO at the next edge.
    logic              v1_q;

    logic [WIDTH-1:0]  mem_q [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        occ_q, occ_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic [3:0]        pending;

    // Counting the read whose data is still in the rom register keeps the
    // FIFO from ever being offered a fifth word.
    assign pending = {1'b0, occ_q} + {3'b000, v1_q};
    assign issue   = (state_q == S_READ) && (pending < 4'd4);
    assign push    = v1_q;
    assign pop     = m_valid && m_ready;

    assign rom_en  = issue;
    assign rom_adr = addr_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign m_valid = (occ_q != 3'd0);
    // Gating with m_valid keeps stale FIFO contents off the bus when empty.
    assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_last  = m_valid && (beats_left_q == ONE_CNT);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        beats_left_d = beats_left_q;
        occ_d        = occ_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d       = base;
                    issue_left_d = count;
                    beats_left_d = count;
                    state_d      = (count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (issue && (issue_left_q == ONE_CNT)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (beats_left_q == ONE_CNT)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            addr_d       = (addr_q == LAST_ADR) ? '0 : addr_q + 1'b1;
            issue_left_d = issue_left_q - ONE_CNT;
        end

        if (pop) begin
            beats_left_d = beats_left_q - ONE_CNT;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            beats_left_q <= '0;
            v1_q         <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            occ_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            beats_left_q <= beats_left_d;
            v1_q         <= issue;
            occ_q        <= occ_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= rom_dat;
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
module tb_rom_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base;
    logic [12:0] count;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [11:0] rom_adr;
    logic [7:0]  rom_dat;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {last, data}
    logic [8:0] sb [$];

    rom_reader #(.WIDTH(8), .DEPTH(4096)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .rom_en  (rom_en),
        .rom_adr (rom_adr),
        .rom_dat (rom_dat),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    // rom model preloaded with mem[i] = i[7:0], one-cycle registered read.
    always @(posedge clk) begin
        if (rst) rom_dat <= 8'h00;
        else if (rom_en) rom_dat <= rom_adr[7:0];
    end

    // Stream monitor: every handshake must match the next expected word.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            logic [8:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%02h last=%0b, expected no beat", m_data, m_last);
            end else begin
                e = sb.pop_front();
                if ({m_last, m_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got data=%02h last=%0b, expected data=%02h last=%0b",
                             m_data, m_last, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; count = '0; m_ready = 1'b1;
        next_cyc();
        next_cyc();
        @(negedge clk);
        checks++;
        if ({busy, done, rom_en, m_valid, m_last} !== 5'b0 || rom_adr !== 12'h000 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b en=%0b vld=%0b last=%0b adr=%03h dat=%02h, expected all 0",
                     busy, done, rom_en, m_valid, m_last, rom_adr, m_data);
        end
        next_cyc();
        rst = 1'b0;
    endtask

    // Full burst with m_ready high; optionally fires an extra start while busy.
    task automatic test_burst(input string name, input logic [11:0] b, input int n, input bit restart);
        logic [11:0] a;
        logic        exp_en, exp_vld, exp_last, exp_done, exp_busy;
        m_ready = 1'b1;
        start = 1'b1; base = b; count = 13'(n);
        for (int i = 0; i < n; i++) begin
            a = b + 12'(i);
            sb.push_back({(i == n - 1), a[7:0]});
        end
        for (int c = 0; c <= n + 4; c++) begin
            if (c == 1) start = 1'b0;
            if (restart && c == 2) begin start = 1'b1; base = 12'h100; count = 13'd2; end
            if (restart && c == 3) start = 1'b0;
            @(negedge clk);
            exp_en   = (c >= 1 && c <= n);
            exp_vld  = (c >= 3 && c <= n + 2);
            exp_last = (c == n + 2);
            exp_done = (c == n + 3);
            exp_busy = (c >= 1 && c <= n + 3);
            checks++;
            if (rom_en !== exp_en) begin
                errors++;
                $display("FAIL %s_rom_en c%0d: got %0b, expected %0b", name, c, rom_en, exp_en);
            end
            if (exp_en) begin
                a = b + 12'(c - 1);
                checks++;
                if (rom_adr !== a) begin
                    errors++;
                    $display("FAIL %s_rom_adr c%0d: got %03h, expected %03h", name, c, rom_adr, a);
                end
            end
            checks++;
            if ({m_valid, m_last, done, busy} !== {exp_vld, exp_last, exp_done, exp_busy}) begin
                errors++;
                $display("FAIL %s_ctl c%0d: got vld/last/done/busy=%b, expected %b", name, c,
                         {m_valid, m_last, done, busy}, {exp_vld, exp_last, exp_done, exp_busy});
            end
            next_cyc();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_words_left: got %0d undelivered, expected 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        int  en_cnt = 0;
        bit  got = 0;
        m_ready = 1'b0;
        start = 1'b1; base = 12'h000; count = 13'd16;
        for (int i = 0; i < 16; i++) sb.push_back({(i == 15), 8'(i)});
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) start = 1'b0;
            @(negedge clk);
            if (rom_en) en_cnt++;
            if (c >= 3) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'h00) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: got vld=%0b dat=%02h, expected vld=1 dat=00", c, m_valid, m_data);
                end
            end
            next_cyc();
        end
        checks++;
        if (en_cnt > 4) begin
            errors++;
            $display("FAIL bp_issue_limit: got %0d rom_en while stalled, expected at most 4", en_cnt);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1;
            next_cyc();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_done_timeout: got no done in 100 cycles, expected done");
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_words_left: got %0d undelivered, expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_zero_count();
        m_ready = 1'b1;
        start = 1'b1; base = 12'h055; count = 13'd0;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) start = 1'b0;
            @(negedge clk);
            checks++;
            if ({done, busy, rom_en, m_valid} !== {(c == 1), (c == 1), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL zero_count c%0d: got done/busy/en/vld=%b, expected %b", c,
                         {done, busy, rom_en, m_valid}, {(c == 1), (c == 1), 2'b00});
            end
            next_cyc();
        end
    endtask

    task automatic test_reset_mid_burst();
        m_ready = 1'b1;
        start = 1'b1; base = 12'h040; count = 13'd8;
        for (int i = 0; i < 8; i++) sb.push_back({(i == 7), 8'(8'h40 + i)});
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) start = 1'b0;
            if (c == 5) rst = 1'b1;
            @(negedge clk);
            next_cyc();
        end
        rst = 1'b0;
        sb.delete();
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, rom_en, m_valid, m_last} !== 5'b0 || rom_adr !== 12'h000 || m_data !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid c%0d: got busy=%0b done=%0b en=%0b vld=%0b last=%0b adr=%03h dat=%02h, expected all 0",
                         c, busy, done, rom_en, m_valid, m_last, rom_adr, m_data);
            end
            next_cyc();
        end
        test_burst("post_rst", 12'h020, 2, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; count = '0; m_ready = 1'b1;
        #1;
        test_reset();
        test_burst("basic", 12'h010, 4, 1'b0);
        test_burst("wrap", 12'hFFE, 4, 1'b0);
        test_backpressure();
        test_zero_count();
        test_reset_mid_burst();
        test_burst("ignore_start", 12'h010, 4, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
